// File: rtl/fu_mem_pipe_if.sv
// Issue/result handshake bundle for the memory functional unit.
// master = issuer and CDB consumer, slave = fu_mem_pipe.
interface fu_mem_pipe_if #(
    parameter int TAG_W = 5
);
    logic             EN;
    logic             ready;
    logic             mem_w;
    logic [2:0]       bhw;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag_in;
    logic             finish;
    logic             ack;
    logic [31:0]      mem_data;
    logic [TAG_W-1:0] tag_out;
    logic             misalign;

    modport master (
        output EN, mem_w, bhw, rs1_data,
        output rs2_data, imm, tag_in, ack,
        input  ready, finish, mem_data,
        input  tag_out, misalign
    );

    modport slave (
        input  EN, mem_w, bhw, rs1_data,
        input  rs2_data, imm, tag_in, ack,
        output ready, finish, mem_data,
        output tag_out, misalign
    );
endinterface

// File: rtl/fu_mem_pipe.sv
// Pipelined load/store unit with internal byte RAM and an
// in-order show-ahead result queue guarded by credits.
module fu_mem_pipe #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5
) (
    input logic         clk,
    input logic         rst_n,
    fu_mem_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int NS = LATENCY - 1;
    localparam int RAM_N = 1 << ADDR_W;

    logic [CW-1:0]     occ;
    logic              acc;
    logic              pop;
    logic [ADDR_W-1:0] addr_in;

    assign bus.ready = (occ < CW'(DEPTH));
    assign acc = bus.EN & bus.ready;
    assign pop = bus.finish & bus.ack;
    assign addr_in = bus.rs1_data[ADDR_W-1:0]
                   + bus.imm[ADDR_W-1:0];

    logic              s0_v;
    logic [ADDR_W-1:0] s0_a;
    logic              s0_w;
    logic [2:0]        s0_f3;
    logic [31:0]       s0_wd;
    logic [TAG_W-1:0]  s0_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v   <= 1'b0;
            s0_a   <= '0;
            s0_w   <= 1'b0;
            s0_f3  <= '0;
            s0_wd  <= '0;
            s0_tag <= '0;
        end else begin
            s0_v <= acc;
            if (acc) begin
                s0_a   <= addr_in;
                s0_w   <= bus.mem_w;
                s0_f3  <= bus.bhw;
                s0_wd  <= bus.rs2_data;
                s0_tag <= bus.tag_in;
            end
        end
    end

    // Reserved funct3 codes with bit 1 set fall into the word class.
    logic is_b;
    logic is_h;
    logic is_w;
    logic mis;

    assign is_b = (s0_f3[1:0] == 2'b00);
    assign is_h = (s0_f3[1:0] == 2'b01);
    assign is_w = s0_f3[1];
    assign mis  = (is_h & s0_a[0])
                | (is_w & (s0_a[1:0] != 2'b00));

    logic [7:0]        ram [RAM_N];
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [7:0]        rb0;
    logic [7:0]        rb1;
    logic [7:0]        rb2;
    logic [7:0]        rb3;
    logic              we;

    assign a1  = s0_a + ADDR_W'(1);
    assign a2  = s0_a + ADDR_W'(2);
    assign a3  = s0_a + ADDR_W'(3);
    assign rb0 = ram[s0_a];
    assign rb1 = ram[a1];
    assign rb2 = ram[a2];
    assign rb3 = ram[a3];
    assign we  = s0_v & s0_w & ~mis;

    always_ff @(posedge clk) begin
        if (we) begin
            ram[s0_a] <= s0_wd[7:0];
            if (!is_b) ram[a1] <= s0_wd[15:8];
            if (is_w) begin
                ram[a2] <= s0_wd[23:16];
                ram[a3] <= s0_wd[31:24];
            end
        end
    end

    logic [31:0] ld;
    logic [31:0] res_d;
    logic        sx;

    assign sx = ~s0_f3[2];

    always_comb begin
        ld = '0;
        unique case (1'b1)
            is_b: ld = {{24{rb0[7] & sx}}, rb0};
            is_h: ld = {{16{rb1[7] & sx}}, rb1, rb0};
            is_w: ld = {rb3, rb2, rb1, rb0};
            default: ld = '0;
        endcase
    end

    assign res_d = (s0_w | mis) ? '0 : ld;

    logic [NS-1:0]    pv;
    logic [NS-1:0]    pm;
    logic [31:0]      pd [NS];
    logic [TAG_W-1:0] pt [NS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pm <= '0;
            for (int i = 0; i < NS; i++) begin
                pd[i] <= '0;
                pt[i] <= '0;
            end
        end else begin
            pv[0] <= s0_v;
            pm[0] <= mis;
            pd[0] <= res_d;
            pt[0] <= s0_tag;
            for (int i = 1; i < NS; i++) begin
                pv[i] <= pv[i-1];
                pm[i] <= pm[i-1];
                pd[i] <= pd[i-1];
                pt[i] <= pt[i-1];
            end
        end
    end

    // Credits cover every in-flight stage, so a push never overflows.
    logic             push;
    logic [31:0]      fd [DEPTH];
    logic [TAG_W-1:0] ft [DEPTH];
    logic [DEPTH-1:0] fm;
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    fc;

    assign push = pv[NS-1];

    always_ff @(posedge clk) begin
        if (push) begin
            fd[wp] <= pd[NS-1];
            ft[wp] <= pt[NS-1];
            fm[wp] <= pm[NS-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            fc  <= '0;
            occ <= '0;
        end else begin
            wp  <= wp + PW'(push);
            rp  <= rp + PW'(pop);
            fc  <= fc + CW'(push) - CW'(pop);
            occ <= occ + CW'(acc) - CW'(pop);
        end
    end

    assign bus.finish   = (fc != '0);
    assign bus.mem_data = bus.finish ? fd[rp] : '0;
    assign bus.tag_out  = bus.finish ? ft[rp] : '0;
    assign bus.misalign = bus.finish & fm[rp];
endmodule

// File: tb/tb_fu_mem_pipe.sv
// Self-checking bench for fu_mem_pipe: directed cases plus random
// traffic against a queue/byte-array reference model.
module tb_fu_mem_pipe;
    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 5;
    localparam int SZ    = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fu_mem_pipe_if #(.TAG_W(TW)) bus ();

    fu_mem_pipe #(
        .ADDR_W(AW), .LATENCY(LAT),
        .DEPTH(DEPTH), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          mis;
        int            due;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem [SZ];
    int edge_n = 0;
    int ncmp   = 0;
    int nerr   = 0;

    task automatic chk(input string nm,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h",
                   nm, obs, exp);
        end
    endtask

    task automatic model(input logic w,
                         input logic [2:0] f3,
                         input logic [31:0] rs1,
                         input logic [31:0] rs2,
                         input logic [31:0] imm,
                         input logic [TW-1:0] tag,
                         output exp_t e);
        logic [31:0] addr;
        logic [31:0] v;
        int n;
        int j;
        addr = rs1 + imm;
        n = (f3[1:0] == 2'b00) ? 1 :
            (f3[1:0] == 2'b01) ? 2 : 4;
        e.tag  = tag;
        e.data = '0;
        e.due  = 0;
        e.mis  = (n == 2 && addr[0]) ||
                 (n == 4 && addr[1:0] != 2'b00);
        if (!e.mis) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                j = (int'(addr[AW-1:0]) + i) % SZ;
                if (w) mem[j] = 8'(rs2 >> (8 * i));
                else v = v | (32'(mem[j]) << (8 * i));
            end
            if (!w && !f3[2]) begin
                if (n == 1 && v[7]) v = v | 32'hFFFF_FF00;
                if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
            end
            if (!w) e.data = v;
        end
    endtask

    task automatic step(output bit acc);
        bit mr;
        bit mf;
        bit pop;
        exp_t e;
        mr = (q.size() < DEPTH);
        mf = (q.size() > 0) && (q[0].due <= edge_n);
        chk("ready", 32'(bus.ready), 32'(mr));
        chk("finish", 32'(bus.finish), 32'(mf));
        if (mf) begin
            chk("mem_data", bus.mem_data, q[0].data);
            chk("tag_out", 32'(bus.tag_out),
                32'(q[0].tag));
            chk("misalign", 32'(bus.misalign),
                32'(q[0].mis));
        end
        acc = bus.EN && mr;
        pop = bus.ack && mf;
        if (acc)
            model(bus.mem_w, bus.bhw, bus.rs1_data,
                  bus.rs2_data, bus.imm, bus.tag_in, e);
        @(posedge clk);
        edge_n++;
        if (pop) q.delete(0);
        if (acc) begin
            e.due = edge_n + LAT;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_op(input bit en, input bit w,
                          input logic [2:0] f3,
                          input logic [31:0] rs1,
                          input logic [31:0] rs2,
                          input logic [31:0] imm,
                          input logic [TW-1:0] tag);
        bus.EN       = en;
        bus.mem_w    = w;
        bus.bhw      = f3;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
        bus.imm      = imm;
        bus.tag_in   = tag;
    endtask

    task automatic issue(input bit w,
                         input logic [2:0] f3,
                         input logic [31:0] rs1,
                         input logic [31:0] rs2,
                         input logic [31:0] imm,
                         input logic [TW-1:0] tag,
                         input bit ackv);
        bit a;
        int n;
        set_op(1'b1, w, f3, rs1, rs2, imm, tag);
        bus.ack = ackv;
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            step(a);
            n++;
        end
        if (!a) begin
            ncmp++;
            nerr++;
            $error("FAIL issue_timeout tag=%0d", tag);
        end
        bus.EN = 1'b0;
    endtask

    task automatic idle(input int n, input bit ackv);
        bit a;
        bus.EN  = 1'b0;
        bus.ack = ackv;
        repeat (n) step(a);
    endtask

    task automatic pop_expect(input logic [31:0] d,
                              input logic [TW-1:0] t,
                              input bit m);
        bit a;
        int n;
        bus.ack = 1'b0;
        n = 0;
        while (!bus.finish && n < 10) begin
            step(a);
            n++;
        end
        chk("lit_finish", 32'(bus.finish), 32'd1);
        chk("lit_data", bus.mem_data, d);
        chk("lit_tag", 32'(bus.tag_out), 32'(t));
        chk("lit_mis", 32'(bus.misalign), 32'(m));
        bus.ack = 1'b1;
        step(a);
        bus.ack = 1'b0;
    endtask

    logic [2:0] f3tab [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int n;
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4,
                  3'd5, 3'd3, 3'd6, 3'd7};
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 3'd0, 0, 0, 0, '0);
        bus.ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_finish", 32'(bus.finish), 32'd0);
        chk("rst_data", bus.mem_data, 32'd0);
        chk("rst_tag", 32'(bus.tag_out), 32'd0);
        chk("rst_mis", 32'(bus.misalign), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < SZ / 4; i++)
            issue(1'b1, 3'd2, 32'(i * 4), $urandom,
                  0, TW'(i), 1'b1);
        idle(4, 1'b1);

        issue(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF,
              4, 5'd1, 1'b1);
        issue(1'b0, 3'd2, 32'h104, 0, 0, 5'd2, 1'b1);
        idle(4, 1'b1);
        issue(1'b0, 3'd2, 32'h100, 0, 4, 5'd3, 1'b0);
        pop_expect(32'hDEAD_BEEF, 5'd3, 1'b0);

        issue(1'b1, 3'd0, 32'h10, 32'h80, 0, 5'd4, 1'b0);
        issue(1'b0, 3'd0, 32'h10, 0, 0, 5'd5, 1'b0);
        issue(1'b0, 3'd4, 32'h10, 0, 0, 5'd6, 1'b0);
        pop_expect(32'h0, 5'd4, 1'b0);
        pop_expect(32'hFFFF_FF80, 5'd5, 1'b0);
        pop_expect(32'h0000_0080, 5'd6, 1'b0);

        issue(1'b1, 3'd2, 32'h20, 32'h1234_5678,
              0, 5'd7, 1'b0);
        issue(1'b1, 3'd1, 32'h20, 32'h8001, 0, 5'd8, 1'b0);
        issue(1'b0, 3'd1, 32'h20, 0, 0, 5'd9, 1'b0);
        issue(1'b0, 3'd5, 32'h20, 0, 0, 5'd10, 1'b0);
        pop_expect(32'h0, 5'd7, 1'b0);
        pop_expect(32'h0, 5'd8, 1'b0);
        pop_expect(32'hFFFF_8001, 5'd9, 1'b0);
        pop_expect(32'h0000_8001, 5'd10, 1'b0);

        issue(1'b0, 3'd1, 32'h11, 0, 0, 5'd11, 1'b0);
        issue(1'b1, 3'd2, 32'h22, 32'hCAFE_F00D,
              0, 5'd12, 1'b0);
        issue(1'b0, 3'd2, 32'h20, 0, 0, 5'd13, 1'b0);
        pop_expect(32'h0, 5'd11, 1'b1);
        pop_expect(32'h0, 5'd12, 1'b1);
        pop_expect(32'h1234_8001, 5'd13, 1'b0);

        issue(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h5A,
              1, 5'd14, 1'b0);
        issue(1'b0, 3'd4, 32'h400, 0, 0, 5'd15, 1'b0);
        issue(1'b0, 3'd4, 32'h0, 0, 0, 5'd16, 1'b0);
        pop_expect(32'h0, 5'd14, 1'b0);
        pop_expect(32'h5A, 5'd15, 1'b0);
        pop_expect(32'h5A, 5'd16, 1'b0);
        issue(1'b1, 3'd2, 32'h3FE, 32'hFFFF_FFFF,
              0, 5'd17, 1'b0);
        issue(1'b0, 3'd4, 32'h0, 0, 0, 5'd18, 1'b0);
        pop_expect(32'h0, 5'd17, 1'b1);
        pop_expect(32'h5A, 5'd18, 1'b0);

        for (int t = 1; t <= 4; t++)
            issue(1'b1, 3'd2, 32'(32'h200 + 4 * t),
                  $urandom, 0, TW'(t), 1'b0);
        set_op(1'b1, 1'b1, 3'd2, 32'h214, $urandom,
               0, 5'd5);
        bus.ack = 1'b0;
        repeat (3) step(a);
        chk("ready_full", 32'(bus.ready), 32'd0);
        pop_expect(32'h0, 5'd1, 1'b0);
        chk("ready_back", 32'(bus.ready), 32'd1);
        step(a);
        chk("tag5_accept", 32'(a), 32'd1);
        bus.EN = 1'b0;
        for (int t = 2; t <= 5; t++)
            pop_expect(32'h0, TW'(t), 1'b0);

        issue(1'b0, 3'd2, 32'h20, 0, 0, 5'd20, 1'b0);
        issue(1'b0, 3'd2, 32'h104, 0, 0, 5'd21, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        chk("mid_rst_finish", 32'(bus.finish), 32'd0);
        chk("mid_rst_data", bus.mem_data, 32'd0);
        chk("mid_rst_tag", 32'(bus.tag_out), 32'd0);
        chk("mid_rst_mis", 32'(bus.misalign), 32'd0);
        q.delete();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5, 1'b1);
        issue(1'b0, 3'd2, 32'h20, 0, 0, 5'd22, 1'b0);
        pop_expect(32'h1234_8001, 5'd22, 1'b0);

        for (int i = 0; i < 600; i++) begin
            set_op($urandom_range(0, 9) < 7,
                   $urandom_range(0, 2) == 0,
                   f3tab[$urandom_range(0, 7)],
                   $urandom, $urandom,
                   32'($urandom_range(0, 15)),
                   TW'($urandom));
            bus.ack = $urandom_range(0, 9) < 6;
            step(a);
        end
        bus.EN  = 1'b0;
        bus.ack = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            step(a);
            n++;
        end
        chk("drain_finish", 32'(bus.finish),
            32'(q.size() > 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/fu_mem_pipe.md
# fu_mem_pipe

Pipelined, parametrised memory functional unit for the out-of-order core. It executes RISC-V loads and stores against an internal byte-addressed, little-endian RAM. It accepts one operation per cycle, tags each with its issuer ID, and returns results in order through a result queue. The result queue holds finished results until the common-data-bus arbiter acknowledges them. It replaces the fixed two-cycle, one-at-a-time memory unit in the execute stage.

## Interface
Parameters:
- ADDR_W, 10, byte-address bits of the RAM (2^ADDR_W bytes); upper address bits ignored
- LATENCY, 2, edges from acceptance to result-queue write; legal range 2..8
- DEPTH, 4, maximum operations in flight plus queued; power of two, ≥2
- TAG_W, 5, width of the issuer tag

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- EN  in  1  issue request
- ready  out  1  unit can accept an operation this cycle
- mem_w  in  1  1 = store, 0 = load
- bhw  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- rs1_data, rs2_data, imm  in  32 each  base, store data, offset
- tag_in  in  TAG_W  issuer tag
- finish  out  1  head of result queue valid
- ack  in  1  consumer takes head result this cycle
- mem_data  out  32  head load result (0 for stores/faults)
- tag_out  out  TAG_W  head tag
- misalign  out  1  head operation faulted on alignment

## Operation
- Accept: EN & ready at an edge registers addr = rs1_data + imm (32-bit, carry dropped), mem_w, bhw, rs2_data and tag_in. EN while ready=0 is ignored; the issuer must hold the request.
- Alignment: half ops fault if addr[0]=1; word ops fault if addr[1:0]≠0. Byte ops never fault. bhw codes 011/110/111 are treated as word.
- Memory stage: this is the cycle after acceptance.
  - Stores write 1/2/4 bytes of rs2_data[7:0]/[15:0]/[31:0] at addr[ADDR_W-1:0], little-endian. The write happens on the edge ending the memory stage. Faulting stores write nothing.
  - Loads read combinationally in the memory stage. Sign-extend for b/h; zero-extend for bu/hu.
- In-order memory access: a load accepted after a store observes that store's data, including when the two are back-to-back.
- Address wrap: bytes of a word at the top of the RAM wrap modulo 2^ADDR_W. Only faulting accesses can straddle, and those write nothing.
- Pipeline: LATENCY−1 valid-tagged stages feed a DEPTH-entry FIFO, and each stage carries {data, tag, misalign}. Stores and faults also produce an entry so the issuer can retire them.
- Result queue: show-ahead. finish = not empty; mem_data, tag_out and misalign show the head entry. finish & ack pops the head; ack while finish=0 is ignored.
- Credits: occupancy = valid pipeline stages + FIFO count, and ready = occupancy < DEPTH.
  - A pop in the same cycle does not raise ready until the next cycle. There is no same-cycle credit return.
  - Accept and pop in the same cycle leave occupancy unchanged.
- Reset (rst_n low, any time):
  - All pipeline valids and the FIFO are cleared immediately.
  - Outputs: ready=1, finish=0, mem_data=0, tag_out=0, misalign=0.
  - RAM contents are not reset. A store whose write edge has already passed stays written; in-flight operations are discarded.

## Timing
- Accept at edge k → memory access during cycle k..k+1 → FIFO write at edge k+LATENCY.
- With the FIFO empty and no backpressure, finish rises in the cycle after edge k+LATENCY. For LATENCY=2 that is 2 cycles after acceptance.
- Throughput is one op/cycle while ack is held high and DEPTH ≥ LATENCY+1.
- The FIFO never overflows because the credit count includes in-flight stages. A push and a pop in the same cycle are both honoured.

## Test plan
- sw rs1=0x100, imm=4, rs2=0xDEADBEEF, then lw from 0x104 the next cycle with ack=1 → store entry (mem_data=0, misalign=0), then load mem_data=0xDEADBEEF. Each finish comes 2 cycles after its acceptance, with tags preserved.
- sb 0x80 at 0x10, then lb and lbu at 0x10 → 0xFFFFFF80 and 0x00000080. sh 0x8001 at 0x20, then lh/lhu → 0xFFFF8001/0x00008001.
- lh at 0x11 and sw at 0x22 → misalign=1 with mem_data=0 for each. A following lw at 0x20 returns the data written previously (unchanged).
- DEPTH=4, ack=0, EN held high with tags 1..5 → ready drops after 4 accepts and tag 5 waits. Then pulse ack once → ready returns the next cycle; tags come out in order 1,2,3,4,5.
- Address wrap: rs1=0xFFFFFFFF, imm=1 (addr 0) and rs1=0x400, imm=0 with ADDR_W=10 → both alias byte 0. sb then lbu returns the stored byte.
- Two loads in flight, rst_n pulsed low mid-pipeline → finish=0 and ready=1 immediately. No stale results appear after release, and a subsequent lw works normally.
